// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers.
// One shift/add or shift/subtract iteration per cycle; MTHI/MTLO writes accepted only while idle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [33:0] trial;
  logic [63:0] prod_fix;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_raw_d   = a_raw_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    mul_sum   = '0;
    rem_shift = '0;
    trial     = '0;
    prod_fix  = '0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          a_raw_d = a_in;
          opa_d   = a_in;
          opb_d   = b_in;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if (!op_q[0]) begin
          opa_d     = opa_q[31] ? -opa_q : opa_q;
          opb_d     = opb_q[31] ? -opb_q : opb_q;
          quo_neg_d = opa_q[31] ^ opb_q[31];
          rem_neg_d = opa_q[31];
        end else begin
          quo_neg_d = 1'b0;
          rem_neg_d = 1'b0;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end

      S_CALC: begin
        if (!op_q[1]) begin
          // multiplier bits are consumed from opb LSB; product accumulates in acc
          mul_sum = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
          acc_d   = {mul_sum, acc_q[31:1]};
          opb_d   = {1'b0, opb_q[31:1]};
        end else begin
          // dividend bits enter the remainder from opa MSB, so acc starts cleared
          rem_shift = {acc_q[63:32], opa_q[31]};
          trial     = {1'b0, rem_shift} - {2'b00, opb_q};
          opa_d     = {opa_q[30:0], 1'b0};
          if (trial[33:32] == 2'b00) begin
            acc_d = {trial[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_DONE;
        if (!op_q[1]) begin
          prod_fix = quo_neg_q ? -acc_q : acc_q;
          hi_d     = prod_fix[63:32];
          lo_d     = prod_fix[31:0];
        end else if (opb_q == 32'd0) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = quo_neg_q ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_raw_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_raw_q   <= a_raw_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] f_op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      la, lb;
    logic [63:0] p;
    int          sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    case (f_op)
      2'd0: begin p = la * lb; return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb,
                        input bit coincide_mthi);
    logic [64:0] exp;
    int          cycles;
    int          busy_cnt;
    logic [31:0] hold_hi, hold_lo;
    bit          moved;
    exp      = ref_model(t_op, ta, tb);
    cycles   = 0;
    busy_cnt = 0;
    moved    = 1'b0;
    hold_hi  = '0;
    hold_lo  = '0;
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    a_in  = ta;
    b_in  = tb;
    hi_we = coincide_mthi;
    lo_we = 1'b0;
    wdata = 32'h5A5A_0F0F;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (cycles == 1) begin
        hold_hi = hi;
        hold_lo = lo;
        if (coincide_mthi) check_eq("mthi_with_start", {32'd0, hi}, {32'd0, 32'h5A5A_0F0F});
      end else if (!done && (hi !== hold_hi || lo !== hold_lo)) begin
        moved = 1'b1;
      end
      if (!done) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
    end while (!done && cycles < 100);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check_eq("latency", 64'(cycles), 64'd35);
    check_eq("busy_cycles", 64'(busy_cnt), 64'd35);
    check_eq("hold_during_calc", {63'd0, moved}, 64'd0);
    check_eq("hi", {32'd0, hi}, {32'd0, exp[63:32]});
    check_eq("lo", {32'd0, lo}, {32'd0, exp[31:0]});
    check_eq("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp[64]});
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    @(negedge clk);
    check_eq("done_width", {63'd0, done}, 64'd0);
    check_eq("busy_after", {63'd0, busy}, 64'd0);
    check_eq("dbz_after", {63'd0, div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] corners [8];
    logic [31:0] ra, rb;
    int          done_seen;
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0000_0002;
    corners[6] = 32'hFFFF_FFFE; corners[7] = 32'h0001_0000;

    rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_eq("mult_min_hi", {32'd0, hi}, 64'h4000_0000);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'd7, 32'd2, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    run_op(2'd3, 32'h1234_5678, 32'd0, 1'b0);
    run_op(2'd3, 32'd100, 32'd9, 1'b0);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);

    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo", {32'd0, lo}, 64'hA5A5_A5A5);
    check_eq("mtlo_hi_kept", {32'd0, hi}, {32'd0, exp_hi});
    hi_we = 1'b1;
    wdata = 32'h0BAD_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi", {32'd0, hi}, 64'h0BAD_F00D);
    check_eq("mthi_lo_kept", {32'd0, lo}, 64'hA5A5_A5A5);

    run_op(2'd1, 32'd12345, 32'd678, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      run_op(2'($urandom), ra, rb, 1'b0);
    end

    @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    check_eq("abort_idle", {63'd0, busy}, 64'd0);

    run_op(2'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
